// File: rtl/avl_stream_pkg.sv
// avl_stream_pkg: shared Avalon-ST beat layout, channel limits and output FSM states
// used by the stream FIFO and its storage.
package avl_stream_pkg;
   localparam int CH_MIN      = 2;
   localparam int AVL_WIDTH   = 512;
   localparam int AVL_MAX_CH  = 4;
   localparam int AVL_EMPTY_W = $clog2(AVL_WIDTH / 8);
   localparam int AVL_CH_W    = $clog2(AVL_MAX_CH);

   // One stored beat; the FIFO's WIDTH/MAX_CH must match this layout.
   typedef struct packed {
      logic [AVL_WIDTH-1:0]   data;
      logic                   sop;
      logic                   eop;
      logic [AVL_EMPTY_W-1:0] empty;
      logic [AVL_CH_W-1:0]    channel;
   } avl_beat_t;

   typedef enum logic {
      ST_IDLE,
      ST_IN_PKT
   } out_state_e;
endpackage

// File: rtl/avl_stream_if.sv
// avl_stream_if: team Avalon-ST interface; rx is the sink side, tx the source side.
interface avl_stream_if #(
   parameter int WIDTH  = 512,
   parameter int MAX_CH = 4
);
   localparam int EMPTY_W = $clog2(WIDTH / 8);
   localparam int CH_W    = $clog2(MAX_CH);

   logic [WIDTH-1:0]   data;
   logic               valid;
   logic               ready;
   logic               sop;
   logic               eop;
   logic [EMPTY_W-1:0] empty;
   logic [CH_W-1:0]    channel;
   logic               almost_full;

   modport rx (input data, valid, sop, eop, empty, channel, output ready, almost_full);
   modport tx (output data, valid, sop, eop, empty, channel, input ready, almost_full);
endinterface

// File: rtl/avl_fifo_ram.sv
// avl_fifo_ram: simple dual-port DEPTH x W storage with one write port and a registered,
// enable-gated read port.
module avl_fifo_ram #(
   parameter  int DEPTH = 32,
   parameter  int W     = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [W-1:0]  i_wr_data,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [W-1:0]  o_rd_data
);
   logic [W-1:0] r_mem [DEPTH];

   // NOTE: the array has no reset so it can map onto block RAM; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       o_rd_data <= '0;
      else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
   end
endmodule

// File: rtl/avl_stream_fifo.sv
// avl_stream_fifo: Avalon-ST FIFO with a registered head and packet-aware downstream gating.
// Define AVL_STREAM_FRAME_CHK_EN to enable input framing checks and frame_err_cnt.
module avl_stream_fifo
   import avl_stream_pkg::*;
#(
   parameter int WIDTH     = AVL_WIDTH,
   parameter int MAX_CH    = AVL_MAX_CH,
   parameter int DEPTH     = 32,
   parameter int AF_THRESH = 24
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_sop,
   input  logic                       in_eop,
   input  logic [$clog2(WIDTH/8)-1:0] in_empty,
   input  logic [$clog2(MAX_CH)-1:0]  in_channel,
   output logic                       in_almost_full,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_sop,
   output logic                       out_eop,
   output logic [$clog2(WIDTH/8)-1:0] out_empty,
   output logic [$clog2(MAX_CH)-1:0]  out_channel,
   input  logic                       out_almost_full,
   output logic [15:0]                frame_err_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   avl_stream_if #(.WIDTH(WIDTH), .MAX_CH(MAX_CH)) u_rx ();
   avl_stream_if #(.WIDTH(WIDTH), .MAX_CH(MAX_CH)) u_tx ();

   assign u_rx.data        = in_data;
   assign u_rx.valid       = in_valid;
   assign u_rx.sop         = in_sop;
   assign u_rx.eop         = in_eop;
   assign u_rx.empty       = in_empty;
   assign u_rx.channel     = in_channel;
   assign in_ready         = u_rx.ready;
   assign in_almost_full   = u_rx.almost_full;
   assign out_data         = u_tx.data;
   assign out_valid        = u_tx.valid;
   assign out_sop          = u_tx.sop;
   assign out_eop          = u_tx.eop;
   assign out_empty        = u_tx.empty;
   assign out_channel      = u_tx.channel;
   assign u_tx.ready       = out_ready;
   assign u_tx.almost_full = out_almost_full;

   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count, w_count_next;
   logic          r_in_ready, r_in_af, r_sel_byp, r_hold;
   avl_beat_t     r_byp, w_in_beat, w_ram_rd, w_head;
   out_state_e    r_state, w_state_next;
   logic          w_accept, w_store, w_pop, w_byp_load, w_ram_load, w_out_valid;

   assign w_in_beat = '{data: u_rx.data, sop: u_rx.sop, eop: u_rx.eop,
                        empty: u_rx.empty, channel: u_rx.channel};

   assign w_accept     = u_rx.valid && r_in_ready;
   assign w_pop        = w_out_valid && u_tx.ready;
   assign w_count_next = r_count + CW'(w_store) - CW'(w_pop);
   // The head register is refilled from the input when the pushed beat becomes the new head,
   // otherwise from the RAM entry behind the one being popped.
   assign w_byp_load   = w_store && ((r_count == '0) || ((r_count == CW'(1)) && w_pop));
   assign w_ram_load   = w_pop && (r_count >= CW'(2));
   assign w_head       = r_sel_byp ? r_byp : w_ram_rd;

   // A sop is held back between packets while downstream warns, unless already offered.
   assign w_out_valid = (r_count != '0) &&
                        ((r_state == ST_IN_PKT) || !w_head.sop || !u_tx.almost_full || r_hold);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_in_ready <= 1'b0;
         r_in_af    <= 1'b0;
         r_sel_byp  <= 1'b0;
         r_hold     <= 1'b0;
         r_byp      <= '0;
      end else begin
         if (w_store) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count    <= w_count_next;
         r_in_ready <= (w_count_next < CW'(DEPTH));
         r_in_af    <= (r_count >= CW'(AF_THRESH));
         r_hold     <= w_out_valid && !u_tx.ready;
         if (w_byp_load) begin
            r_byp     <= w_in_beat;
            r_sel_byp <= 1'b1;
         end else if (w_ram_load) begin
            r_sel_byp <= 1'b0;
         end
      end
   end

   avl_fifo_ram #(.DEPTH(DEPTH), .W($bits(avl_beat_t))) u_ram (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_store),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_in_beat),
      .i_rd_en   (w_ram_load),
      .i_rd_addr (r_rd_ptr + AW'(1)),
      .o_rd_data (w_ram_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // NOTE: next-state gets a default before the case so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_pop && w_head.sop && !w_head.eop) w_state_next = ST_IN_PKT;
         ST_IN_PKT: if (w_pop && w_head.eop)                w_state_next = ST_IDLE;
         default:                                           w_state_next = ST_IDLE;
      endcase
   end

   assign u_rx.ready       = r_in_ready;
   assign u_rx.almost_full = r_in_af;
   assign u_tx.valid       = w_out_valid;
   assign u_tx.data        = w_head.data;
   assign u_tx.sop         = w_head.sop;
   assign u_tx.eop         = w_head.eop;
   assign u_tx.empty       = w_head.empty;
   assign u_tx.channel     = w_head.channel;

`ifdef AVL_STREAM_FRAME_CHK_EN
   logic        r_in_pkt;
   logic [15:0] r_frame_err;
   logic        w_frame_err;

   // A sop inside a packet restarts it; a non-sop beat outside a packet is dropped.
   assign w_store     = w_accept && (u_rx.sop || r_in_pkt);
   assign w_frame_err = w_accept && (u_rx.sop == r_in_pkt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_pkt    <= 1'b0;
         r_frame_err <= '0;
      end else begin
         if (w_store) r_in_pkt <= !u_rx.eop;
         if (w_frame_err && (r_frame_err != '1)) r_frame_err <= r_frame_err + 16'd1;
      end
   end

   assign frame_err_cnt = r_frame_err;
`else
   assign w_store       = w_accept;
   assign frame_err_cnt = '0;
`endif
endmodule

// File: tb/tb_avl_stream_fifo.sv
// tb_avl_stream_fifo: directed vector table plus hand-written sequences for avl_stream_fifo.
module tb_avl_stream_fifo;
   localparam int WIDTH = 512, MAX_CH = 4, DEPTH = 32, AF_THRESH = 24;
   localparam int EW = $clog2(WIDTH / 8), CHW = $clog2(MAX_CH);

   logic             clk = 1'b0, rst_n = 1'b1;
   logic [WIDTH-1:0] in_data = '0, out_data;
   logic             in_valid = 1'b0, in_ready, in_sop = 1'b0, in_eop = 1'b0, in_almost_full;
   logic [EW-1:0]    in_empty = '0, out_empty;
   logic [CHW-1:0]   in_channel = '0, out_channel;
   logic             out_valid, out_ready = 1'b0, out_sop, out_eop, out_almost_full = 1'b0;
   logic [15:0]      frame_err_cnt;

   avl_stream_fifo #(.WIDTH(WIDTH), .MAX_CH(MAX_CH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
      .in_eop(in_eop), .in_empty(in_empty), .in_channel(in_channel),
      .in_almost_full(in_almost_full),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
      .out_eop(out_eop), .out_empty(out_empty), .out_channel(out_channel),
      .out_almost_full(out_almost_full), .frame_err_cnt(frame_err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   int checks = 0, failures = 0, rx_cnt = 0;
   int unsigned exp_q[$];
   bit sb_en = 1'b0;

   typedef struct {
      logic v, sop, eop; logic [EW-1:0] emp; logic [CHW-1:0] ch; logic [31:0] d;
      logic ordy, oaf;
      logic x_irdy, x_ovld; logic [31:0] x_d; logic x_sop, x_eop;
      logic [EW-1:0] x_emp; logic [CHW-1:0] x_ch;
   } vec_t;

   function automatic vec_t mkv(input logic v, sop, eop, input logic [EW-1:0] emp,
                                input logic [CHW-1:0] ch, input logic [31:0] d,
                                input logic ordy, oaf, x_irdy, x_ovld, input logic [31:0] x_d,
                                input logic x_sop, x_eop, input logic [EW-1:0] x_emp,
                                input logic [CHW-1:0] x_ch);
      vec_t r;
      r.v = v; r.sop = sop; r.eop = eop; r.emp = emp; r.ch = ch; r.d = d;
      r.ordy = ordy; r.oaf = oaf; r.x_irdy = x_irdy; r.x_ovld = x_ovld; r.x_d = x_d;
      r.x_sop = x_sop; r.x_eop = x_eop; r.x_emp = x_emp; r.x_ch = x_ch;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_data(input string name, input logic [31:0] d);
      check({name, "_lo"}, out_data[63:0], {d, d});
      check({name, "_hi"}, out_data[WIDTH-1 -: 64], {d, d});
   endtask

   task automatic drive(input logic v, sop, eop, input logic [EW-1:0] emp,
                        input logic [CHW-1:0] ch, input logic [31:0] d);
      in_valid = v; in_sop = sop; in_eop = eop; in_empty = emp; in_channel = ch;
      in_data = {16{d}};
   endtask

   // Wait for the falling edge and run the scoreboard on this cycle's handshakes.
   task automatic sample();
      @(negedge clk);
      if (sb_en) begin
         if (in_valid && in_ready) exp_q.push_back(in_data[31:0]);
         if (out_valid && out_ready) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL sb_extra: got %0h expected no beat", out_data[31:0]);
            end else begin
               check("sb_data", out_data[63:0], {2{exp_q.pop_front()}});
            end
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name, input int budget);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
         sample(); advance();
      end
      check(name, exp_q.size(), 0);
   endtask

   vec_t vt[12];
   int unsigned got[$];
   int unsigned exp_frm[$];
   int sent;

   initial begin
      vt[0]  = mkv(0,0,0,0,0,0,         1,0, 1,0,0,0,0,0,0);
      vt[1]  = mkv(1,1,1,5,2,32'hA1,    0,0, 1,0,0,0,0,0,0);
      vt[2]  = mkv(0,0,0,0,0,0,         0,0, 1,1,32'hA1,1,1,5,2);
      vt[3]  = mkv(0,0,0,0,0,0,         0,0, 1,1,32'hA1,1,1,5,2);
      vt[4]  = mkv(0,0,0,0,0,0,         1,0, 1,1,32'hA1,1,1,5,2);
      vt[5]  = mkv(1,1,0,0,1,32'hB2,    1,0, 1,0,0,0,0,0,0);
      vt[6]  = mkv(1,0,1,3,1,32'hC3,    1,0, 1,1,32'hB2,1,0,0,1);
      vt[7]  = mkv(0,0,0,0,0,0,         1,1, 1,1,32'hC3,0,1,3,1);
      vt[8]  = mkv(1,1,1,0,3,32'hD4,    1,1, 1,0,0,0,0,0,0);
      vt[9]  = mkv(0,0,0,0,0,0,         1,1, 1,0,0,0,0,0,0);
      vt[10] = mkv(0,0,0,0,0,0,         1,0, 1,1,32'hD4,1,1,0,3);
      vt[11] = mkv(0,0,0,0,0,0,         1,0, 1,0,0,0,0,0,0);

      // Reset state while rst_n is low, then in_ready rises on the first edge after release.
      #1 rst_n = 1'b0;
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_in_af", in_almost_full, 0);
      check("rst_frame_err", frame_err_cnt, 0);
      check("rst_out_data", out_data[63:0], 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      sample();
      check("rel_in_ready_before_edge", in_ready, 0);
      advance();

      foreach (vt[i]) begin
         drive(vt[i].v, vt[i].sop, vt[i].eop, vt[i].emp, vt[i].ch, vt[i].d);
         out_ready = vt[i].ordy; out_almost_full = vt[i].oaf;
         sample();
         check($sformatf("v%0d_in_ready", i), in_ready, vt[i].x_irdy);
         check($sformatf("v%0d_out_valid", i), out_valid, vt[i].x_ovld);
         check($sformatf("v%0d_in_af", i), in_almost_full, 0);
         if (vt[i].x_ovld) begin
            check_data($sformatf("v%0d_data", i), vt[i].x_d);
            check($sformatf("v%0d_sop", i), out_sop, vt[i].x_sop);
            check($sformatf("v%0d_eop", i), out_eop, vt[i].x_eop);
            check($sformatf("v%0d_empty", i), out_empty, vt[i].x_emp);
            check($sformatf("v%0d_channel", i), out_channel, vt[i].x_ch);
         end
         advance();
      end
      drive(0,0,0,0,0,0); out_almost_full = 1'b0;

      // Fill to DEPTH with the output stalled; almost_full lags the 24th push by one cycle.
      sb_en = 1'b1; out_ready = 1'b0;
      for (int n = 1; n <= DEPTH; n++) begin
         drive(1,1,1,0,0,32'(n - 1));
         sample();
         check($sformatf("fill%0d_in_ready", n), in_ready, 1);
         check($sformatf("fill%0d_in_af", n), in_almost_full, (n >= AF_THRESH + 2) ? 1 : 0);
         advance();
      end
      drive(0,0,0,0,0,0);
      sample();
      check("full_in_ready", in_ready, 0);
      check("full_in_af", in_almost_full, 1);
      advance();
      out_ready = 1'b1;
      for (int p = 0; p < 9; p++) begin sample(); advance(); end
      out_ready = 1'b0;
      sample();
      check("pop9_in_af_lag", in_almost_full, 1);
      advance();
      sample();
      check("pop9_in_af", in_almost_full, 0);
      advance();
      for (int n = 32; n <= 40; n++) begin drive(1,1,1,0,0,32'(n)); sample(); advance(); end
      drive(1,1,1,0,0,32'd41); out_ready = 1'b1;
      sample();
      check("full_pop_in_ready", in_ready, 0);
      advance();
      sample();
      check("after_pop_in_ready", in_ready, 1);
      advance();
      drain("fill_drain", 60);
      sample();
      check("fill_drained_valid", out_valid, 0);
      advance();

      // 100 beats with random backpressure on both sides across several pointer wraps.
      sent = 0; rx_cnt = 0;
      for (int cyc = 0; cyc < 3000 && (sent < 100 || exp_q.size() > 0); cyc++) begin
         drive((sent < 100) && ($urandom_range(0, 3) != 0), 1, 1, 0, 0, 32'h1000 + 32'(sent));
         out_ready = 1'($urandom_range(0, 1));
         sample();
         if (in_valid && in_ready) sent++;
         advance();
      end
      drive(0,0,0,0,0,0); out_ready = 1'b1;
      check("wrap_sent", sent, 100);
      check("wrap_rcvd", rx_cnt, 100);
      sample();
      check("wrap_no_extra", out_valid, 0);
      advance();

      // Downstream warning during a 4-beat packet: the packet finishes, the next sop waits.
      out_ready = 1'b0;
      drive(1,1,0,0,1,32'h200); sample(); advance();
      drive(1,0,0,0,1,32'h201); sample(); advance();
      drive(1,0,0,0,1,32'h202); sample(); advance();
      drive(1,0,1,0,1,32'h203); sample(); advance();
      drive(1,1,1,0,2,32'h300); sample(); advance();
      drive(0,0,0,0,0,0); out_ready = 1'b1;
      sample();
      check("bp_p0_valid", out_valid, 1);
      advance();
      out_almost_full = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         sample();
         check($sformatf("bp_p%0d_valid", k), out_valid, 1);
         advance();
      end
      for (int k = 0; k < 3; k++) begin
         sample();
         check($sformatf("bp_hold%0d", k), out_valid, 0);
         advance();
      end
      out_almost_full = 1'b0;
      sample();
      check("bp_release_valid", out_valid, 1);
      advance();
      sample();
      check("bp_done", out_valid, 0);
      check("bp_sb_empty", exp_q.size(), 0);
      advance();

      // Framing: sop, sop, eop, orphan, then a clean single-beat packet.
      sb_en = 1'b0;
      check("frm_cnt_before", frame_err_cnt, 0);
      out_ready = 1'b0;
      drive(1,1,0,0,0,32'h51); sample(); advance();
      drive(1,1,0,0,0,32'h52); sample(); advance();
      drive(1,0,1,0,0,32'h53); sample(); advance();
      drive(1,0,0,0,0,32'h54); sample(); check("frm_orphan_ready", in_ready, 1); advance();
      drive(1,1,1,0,0,32'h55); sample(); advance();
      drive(0,0,0,0,0,0); out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         sample();
         if (out_valid) got.push_back(out_data[31:0]);
         advance();
      end
`ifdef AVL_STREAM_FRAME_CHK_EN
      exp_frm = '{32'h51, 32'h52, 32'h53, 32'h55};
      check("frm_err_cnt", frame_err_cnt, 2);
`else
      exp_frm = '{32'h51, 32'h52, 32'h53, 32'h54, 32'h55};
      check("frm_err_cnt", frame_err_cnt, 0);
`endif
      check("frm_beats", got.size(), exp_frm.size());
      for (int i = 0; i < exp_frm.size() && i < got.size(); i++)
         check($sformatf("frm_beat%0d", i), got[i], exp_frm[i]);

      // Reset with 5 beats buffered: everything is discarded.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin drive(1,1,1,0,0,32'h400 + 32'(i)); sample(); advance(); end
      drive(0,0,0,0,0,0);
      sample();
      check("prerst_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_in_af", in_almost_full, 0);
      check("midrst_frame_err", frame_err_cnt, 0);
      check("midrst_out_data", out_data[63:0], 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      sample();
      check("rel2_in_ready_before_edge", in_ready, 0);
      advance();
      drive(1,1,1,0,0,32'h777);
      sample();
      check("rel2_in_ready", in_ready, 1);
      check("rel2_empty", out_valid, 0);
      advance();
      drive(0,0,0,0,0,0); out_ready = 1'b1;
      sample();
      check("rel2_first_valid", out_valid, 1);
      check_data("rel2_first", 32'h777);
      advance();
      sample();
      check("rel2_only_one", out_valid, 0);
      advance();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/avl_stream_fifo.md
AVL_STREAM_FIFO -- requirements
Module: avl_stream_fifo

Interface
REQ-001 SHALL have parameters, one per line:
  WIDTH 512: data width in bits.
  MAX_CH 4: channel count, minimum CH_MIN.
  DEPTH 32: entries, power of two, at least 4.
  AF_THRESH 24: occupancy at which in_almost_full asserts, less than DEPTH.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock.
  rst_n  in  1  asynchronous, active-low reset.
  in_data  in  WIDTH  upstream beat data.
  in_valid  in  1  upstream beat valid.
  in_ready  out  1  block can accept a beat.
  in_sop  in  1  start of packet.
  in_eop  in  1  end of packet.
  in_empty  in  $clog2(WIDTH/8)  unused bytes in the eop beat.
  in_channel  in  $clog2(MAX_CH)  channel tag.
  in_almost_full  out  1  backpressure warning to upstream.
  out_data  out  WIDTH  downstream beat data.
  out_valid  out  1  downstream beat valid.
  out_ready  in  1  downstream accepts the beat.
  out_sop  out  1  start of packet.
  out_eop  out  1  end of packet.
  out_empty  out  $clog2(WIDTH/8)  unused bytes in the eop beat.
  out_channel  out  $clog2(MAX_CH)  channel tag.
  out_almost_full  in  1  backpressure warning from downstream.
  frame_err_cnt  out  16  count of framing errors.
REQ-003 SHALL map the in_* ports onto the rx modport and the out_* ports onto the tx modport of the team's Avalon stream interface.

Function
REQ-004 SHALL store each beat as {data, sop, eop, empty, channel} in a DEPTH-entry circular buffer.
REQ-005 SHALL drive in_ready = (count < DEPTH); a push occurs on in_valid && in_ready.
REQ-006 SHALL pop on out_valid && out_ready.
REQ-007 SHALL present the head entry registered on out_*, so a push into an empty FIFO gives out_valid one cycle later; there is no same-cycle pass-through.
REQ-008 SHALL keep out_* stable while out_valid && !out_ready.
REQ-009 SHALL handle a simultaneous push and pop by leaving count unchanged and advancing both pointers.
REQ-010 SHALL wrap the read and write pointers modulo DEPTH; count is $clog2(DEPTH)+1 bits.
REQ-011 SHALL register in_almost_full = (count >= AF_THRESH), one cycle after count changes.
REQ-012 SHALL run an output state machine with two states:
  IDLE (between packets): if out_almost_full is 1, hold out_valid at 0 at the sop beat; otherwise launch the beat, and on an accepted sop without eop go to IN_PKT.
  IN_PKT: ignore out_almost_full; on an accepted eop go to IDLE.
REQ-013 SHALL, when full with out_ready high, accept a new push only in the cycle after the pop.

Reset
REQ-014 SHALL, on rst_n low and asynchronously, clear pointers and count, force out_valid=0, in_ready=0, in_almost_full=0, frame_err_cnt=0, other out_* = 0, and state IDLE.
REQ-015 SHALL raise in_ready the first clk edge after rst_n deasserts.
REQ-016 SHALL discard buffered beats when reset is asserted mid-packet, with no partial-packet recovery.

Configuration
REQ-017 SHALL, with AVL_STREAM_FRAME_CHK_EN defined, track input framing:
  sop while inside a packet: frame_err_cnt increments (saturating), and the beat is stored, starting a new packet.
  beat without sop while outside a packet: frame_err_cnt increments, and the beat is accepted (in_ready honoured) but not stored.
REQ-018 SHALL, without AVL_STREAM_FRAME_CHK_EN, store all beats unchecked and tie frame_err_cnt to 0.

Structure
REQ-019 SHALL place the beat-entry struct typedef and CH_MIN in the shared avl stream package or header.
REQ-020 SHALL use one sub-module, avl_fifo_ram: a simple dual-port DEPTH x entry memory with registered read.

Verification
REQ-021 Single beat: push 1 beat (sop=eop=1, ch=2, empty=5) into an empty FIFO -> out_valid at cycle+1 with identical fields.
REQ-022 Fill: out_ready=0, push 32 beats -> in_ready=0 after the 32nd, in_almost_full=1 the cycle after the 24th push; pop 9 -> in_almost_full=0.
REQ-023 Wrap: stream 100 beats with random out_ready -> output order and data match input, no loss or duplication across pointer wrap.
REQ-024 Downstream backpressure: out_almost_full=1 while a 4-beat packet is mid-flight -> all 4 beats delivered, the next sop held until out_almost_full=0.
REQ-025 Framing (macro on): sop,sop,eop followed by an orphan beat -> frame_err_cnt=2, orphan absent at output; with the macro off -> count stays 0 and all beats output.
REQ-026 Reset: rst_n low with 5 beats buffered -> out_valid=0 immediately, count=0, and after release the first pushed beat is the first output.
